// File: rtl/demux_16_reg.sv
// Registered 1-to-16 word distributor: one producer stream steered to one channel
// or broadcast to all 16, each channel holding its word until its consumer acks.
module demux_16_reg (
    input  logic         clock,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   select,
    input  logic         broadcast,
    input  logic [31:0]  data_in,
    output logic [511:0] out_data,
    output logic [15:0]  out_valid,
    input  logic [15:0]  out_ack,
    output logic [15:0]  accept_count
);

    logic [15:0] free;
    logic        accept;
    logic [15:0] write_en;

    // A channel being drained this cycle can take a new word (pass-through).
    always_comb begin
        free     = ~out_valid | out_ack;
        in_ready = broadcast ? (&free) : free[select];
        accept   = in_valid & in_ready;
        write_en = 16'h0000;
        if (accept) begin
            write_en = broadcast ? 16'hFFFF : (16'h0001 << select);
        end
    end

    // A write beats a same-cycle ack; an ack on an empty channel changes nothing.
    always_ff @(posedge clock) begin
        if (!reset) begin
            out_data     <= '0;
            out_valid    <= '0;
            accept_count <= '0;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (write_en[i]) begin
                    out_data[32*i +: 32] <= data_in;
                    out_valid[i]         <= 1'b1;
                end else if (out_ack[i]) begin
                    out_valid[i]         <= 1'b0;
                end
            end
            if (accept) begin
                accept_count <= accept_count + 16'd1;
            end
        end
    end

endmodule
